// File: rtl/pu_accum_act.sv
// Accumulates NUM_CHUNKS signed partial sums, then shifts, applies ReLU and
// saturates to an OUT_W-bit activation presented on a valid/ready output.
module pu_accum_act #(
  parameter int IN_W       = 12,
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_W      = 16,
  parameter int SHIFT      = 4,
  parameter int OUT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       chunk_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [3:0] LAST_CHUNK = 4'(NUM_CHUNKS - 1);

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic signed [ACC_W-1:0] in_ext, sum, s_sh;
  logic [3:0]              cnt_nx;
  logic [OUT_W-1:0]        act, out_nx;

  assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sum    = acc + in_ext;
  assign s_sh   = sum >>> SHIFT;

  // Shift first, then ReLU; any set bit above OUT_W on a positive value saturates.
  always_comb begin
    act = s_sh[OUT_W-1:0];
    if (s_sh[ACC_W-1])
      act = '0;
    else if (|s_sh[ACC_W-2:OUT_W])
      act = '1;
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = chunk_cnt;
    out_nx   = out_data;
    case (state)
      ACCUM: begin
        if (clr) begin
          acc_nx = '0;
          cnt_nx = '0;
        end else if (in_valid) begin
          if (chunk_cnt == LAST_CHUNK) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            out_nx   = act;
            state_nx = HOLD;
          end else begin
            acc_nx = sum;
            cnt_nx = chunk_cnt + 4'd1;
          end
        end
      end
      HOLD: begin
        if (clr || out_ready)
          state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      chunk_cnt <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      chunk_cnt <= cnt_nx;
      out_data  <= out_nx;
    end
  end

  // Handshake flags are pure state decodes, so out_ready never reaches in_ready.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

endmodule

// File: doc/pu_accum_act.md
Name: pu_accum_act

Overview:
- Downstream consumer of the 4-tap processing unit's registered 12-bit partial sum.
- Accumulates NUM_CHUNKS consecutive partial sums into one neuron pre-activation, so one 4-tap unit can serve a 4*NUM_CHUNKS-input neuron.
- Applies arithmetic right shift, ReLU and unsigned saturation, then presents the 5-bit activation on a valid/ready output.
- The activation width matches the 5-bit input width of the next unit.

Parameters:
- IN_W, 12, width of incoming partial sum (two's complement signed).
- NUM_CHUNKS, 4, partial sums per neuron result; legal range 1..16.
- ACC_W, 16, accumulator width (signed); must be >= IN_W + ceil(log2(NUM_CHUNKS)).
- SHIFT, 4, arithmetic right shift applied to the final sum before activation.
- OUT_W, 5, activation width (unsigned).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous discard of the partial accumulation; returns the block to ACCUM.
- in_data  input  IN_W  signed partial sum from the processing unit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_W  activation result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- chunk_cnt  output  4  number of chunks accepted in the current accumulation.

Behaviour:
- Reset (async, rst=1):
  - state=ACCUM, acc=0, chunk_cnt=0.
  - out_data=0, out_valid=0.
  - in_ready=1 as soon as rst deasserts.
  - Reset mid-accumulation or mid-HOLD discards everything; no output is produced.
- FSM states: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid=1 on a rising edge.
  - On accept: acc <= acc + sign_extend(in_data), and chunk_cnt increments.
  - On acceptance of chunk number NUM_CHUNKS:
    - Compute s = (acc + sign_extend(in_data)) >>> SHIFT.
    - Register out_data = 0 if s<0; 2^OUT_W-1 if s>2^OUT_W-1; else s[OUT_W-1:0].
    - out_valid <= 1, acc <= 0, chunk_cnt <= 0, state <= HOLD.
  - Latency: out_valid rises on the edge that accepts the last chunk, i.e. it is visible in the following cycle.
- HOLD:
  - in_ready=0, and in_data is ignored.
  - out_data and out_valid stay stable until out_ready=1 on an edge; then out_valid <= 0 and state <= ACCUM.
  - Result is one bubble cycle per result; no same-cycle re-acceptance.
- in_ready and out_valid are registered or pure state decodes; no combinational path from out_ready to in_ready.
- clr:
  - In ACCUM, takes priority over an in_valid beat in the same cycle: acc <= 0, chunk_cnt <= 0, the beat is dropped.
  - In HOLD, drops the pending result: out_valid <= 0, state <= ACCUM. out_data keeps its last value.
- NUM_CHUNKS=1: every accepted beat yields a result.
- Accumulator never overflows within legal parameters. The shift is arithmetic (sign-preserving) and is applied before ReLU.

Test Plan:
- Reset during ACCUM after 2 chunks (100, 200) -> out_valid=0 and chunk_cnt=0 immediately; the next 4 chunks 1,1,1,14 -> acc 17, s=1, out_data=1.
- Basic: chunks 100, 200, -50, 30 with out_ready=1 -> sum 280, s=17, out_data=17; out_valid high for exactly one cycle after the 4th accept, then in_ready=1 the cycle after.
- Saturation/ReLU: chunks 2047 x4 -> sum 8188, s=511, out_data=31. Chunks -100, -20, 10, 5 -> sum -105, s=-7, out_data=0.
- Backpressure: complete a result, then hold out_ready=0 for 3 cycles while in_valid=1 with data 500 -> out_data stable, in_ready=0, no beats accepted, chunk_cnt=0. Raise out_ready -> out_valid falls, then accumulation resumes.
- clr: accept 300, 300, then assert clr with in_valid=1 and in_data=300 -> chunk_cnt=0. Then chunks 16, 16, 16, 16 -> sum 64, out_data=4.
- Back-to-back stream with in_valid=1 always: 8 chunks of 40 -> two results of 10, separated by the single HOLD bubble; 9 accepts total never occur in 10 cycles.
